imem_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of the single-port async RAM used as instruction memory. It takes 8-bit bytes from the debug UART receiver and packs them big-endian into 32-bit words. It drives the RAM write port (write enable, data, byte address) and advances the address by 4 per word. Loading ends on the HALT word or when memory is full; completion is then reported to the debug unit.

---
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the instruction RAM. It takes bytes from the debug UART
// receiver and packs them big-endian into 32-bit words (the first byte lands in
// [31:24]). It then drives the RAM write port with one write strobe per word,
// advancing the byte address by 4 after each word. A load ends on HALT_WORD,
// which is itself written, or when the last word of the RAM has been written.
// In either case the loader parks in DONE until the next start pulse.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   After the HALT write, one more byte is expected. o_error is set if that byte
//   differs from the XOR of all program bytes, HALT bytes included. A load that
//   ends on memory-full skips this byte. Without the macro, o_error is tied 0.
//
// Parameters
//   NB_DATA   : word width, 32 (packing is 4 bytes per word)
//   NB_ADDR   : RAM byte-address width, capacity 2**NB_ADDR bytes
//   HALT_WORD : end-of-program marker
//
// Ports
//   clk            in   system clock, rising edge
//   i_reset        in   asynchronous active-high reset
//   i_start        in   start pulse, honoured only in IDLE or DONE
//   i_rx_data      in   received byte
//   i_rx_valid     in   one-cycle strobe qualifying i_rx_data
//   o_write_enable out  RAM write strobe, one cycle per word
//   o_data         out  packed word (registered)
//   o_addr_w       out  RAM byte address of the current word (registered)
//   o_busy         out  load in progress
//   o_done         out  load finished (level)
//   o_word_count   out  words written in this load
//   o_error        out  checksum mismatch
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_write_enable,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_ADDR-1:0] o_addr_w,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR-2:0] o_word_count,
  output logic               o_error
);

  // The word counter must hold 2**(NB_ADDR-2) on a full load, hence NB_ADDR-1 bits.
  localparam int                 NB_WCNT   = NB_ADDR - 1;
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t state_q, state_d;

  // Only the three leading bytes are buffered. The fourth byte goes straight
  // into the word register.
  logic [NB_DATA-9:0] shreg_q;
  logic [NB_DATA-1:0] data_q;
  logic [1:0]         byte_cnt_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_WCNT-1:0] word_cnt_q;

  logic start_load;    // clear per-load state and enter RECV
  logic take_byte;     // shift i_rx_data into the word being assembled
  logic advance_addr;  // move to the next word slot after a non-final write
  logic is_halt;
  logic at_last;

  assign is_halt = (data_q == HALT_WORD);
  assign at_last = (addr_q == LAST_ADDR);

`ifdef LOADER_CHECKSUM_EN
  logic       check_byte;  // i_rx_data is the trailing checksum byte
  logic [7:0] csum_q;
  logic       error_q;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    start_load   = 1'b0;
    take_byte    = 1'b0;
    advance_addr = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    check_byte   = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          start_load = 1'b1;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        if (i_rx_valid) begin
          take_byte = 1'b1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          // A byte arriving in this cycle is already the checksum.
          if (i_rx_valid) begin
            check_byte = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d    = S_CHECK;
          end
`else
          state_d = S_DONE;
`endif
        end else if (at_last) begin
          state_d = S_DONE;  // memory full: the address is held, never wrapped
        end else begin
          advance_addr = 1'b1;
          state_d      = S_RECV;
          // A byte arriving in the write cycle becomes byte 0 of the next word.
          take_byte    = i_rx_valid;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (i_rx_valid) begin
          check_byte = 1'b1;
          state_d    = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      shreg_q    <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      if (start_load) begin
        byte_cnt_q <= '0;
        addr_q     <= '0;
        word_cnt_q <= '0;
      end
      if (take_byte) begin
        shreg_q    <= {shreg_q[NB_DATA-17:0], i_rx_data};
        byte_cnt_q <= byte_cnt_q + 2'd1;  // wraps to 0 on the fourth byte
        if (byte_cnt_q == 2'd3) data_q <= {shreg_q, i_rx_data};
      end
      // The terminating write is counted too.
      if (state_q == S_WRITE) word_cnt_q <= word_cnt_q + NB_WCNT'(1);
      if (advance_addr)       addr_q     <= addr_q + NB_ADDR'(4);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (start_load) begin
        csum_q  <= '0;
        error_q <= 1'b0;
      end
      if (take_byte)  csum_q  <= csum_q ^ i_rx_data;
      if (check_byte) error_q <= (i_rx_data != csum_q);
    end
  end

  assign o_error = error_q;
  assign o_busy  = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
  assign o_error = 1'b0;
  assign o_busy  = (state_q == S_RECV) || (state_q == S_WRITE);
`endif

  // The strobe decodes from the state register, so an asserted reset drops it at once.
  assign o_write_enable = (state_q == S_WRITE);
  assign o_done         = (state_q == S_DONE);
  assign o_data         = data_q;
  assign o_addr_w       = addr_q;
  assign o_word_count   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader, instantiated with a 16-byte RAM (NB_ADDR=4)
// so that memory-full termination is reached quickly.
//
// A transaction-level model tracks the load: the bytes of the word being
// assembled, the number of words written, and whether the loader is loading,
// waiting for a checksum, or finished. A compare thread checks the DUT against
// this model on every falling edge. Hand-computed literal expectations after
// each scenario pin the model itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int          NB_DATA   = 32;
  localparam int          NB_ADDR   = 4;
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
  localparam int          CAP_WORDS = (1 << NB_ADDR) / 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit          CHK_EN    = 1'b1;
`else
  localparam bit          CHK_EN    = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_start = 1'b0;
  logic [7:0]         i_rx_data = 8'h00;
  logic               i_rx_valid = 1'b0;
  logic               o_write_enable;
  logic [NB_DATA-1:0] o_data;
  logic [NB_ADDR-1:0] o_addr_w;
  logic               o_busy;
  logic               o_done;
  logic [NB_ADDR-2:0] o_word_count;
  logic               o_error;

  imem_loader #(
    .NB_DATA   (NB_DATA),
    .NB_ADDR   (NB_ADDR),
    .HALT_WORD (HALT)
  ) dut (
    .clk            (clk),
    .i_reset        (rst),
    .i_start        (i_start),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_write_enable (o_write_enable),
    .o_data         (o_data),
    .o_addr_w       (o_addr_w),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_word_count   (o_word_count),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  bit          m_loading = 1'b0;  // collecting program bytes
  bit          m_check   = 1'b0;  // HALT written, waiting for the checksum byte
  bit          m_done    = 1'b0;
  bit          m_wr      = 1'b0;  // a complete word is being written this cycle
  logic [31:0] m_wr_word = '0;
  logic [7:0]  m_bytes[$];
  int          m_words   = 0;
  logic [7:0]  m_sum     = '0;
  bit          m_err     = 1'b0;

  task automatic model_clear();
    m_loading = 1'b0;
    m_check   = 1'b0;
    m_done    = 1'b0;
    m_wr      = 1'b0;
    m_wr_word = '0;
    m_bytes.delete();
    m_words   = 0;
    m_sum     = '0;
    m_err     = 1'b0;
  endtask

  task automatic absorb(input logic [7:0] b);
    m_bytes.push_back(b);
    m_sum = m_sum ^ b;
    if (m_bytes.size() == 4) begin
      m_wr      = 1'b1;
      m_wr_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      m_bytes.delete();
    end
  endtask

  task automatic finish_check(input logic [7:0] b);
    m_check = 1'b0;
    m_done  = 1'b1;
    m_err   = (b != m_sum);
  endtask

  // Advance the model by one clock edge, using the inputs of the cycle just ended.
  task automatic model_step();
    if (m_wr) begin
      m_wr = 1'b0;
      m_words++;
      if (m_wr_word == HALT) begin
        m_loading = 1'b0;
        if (CHK_EN) m_check = 1'b1;
        else        m_done  = 1'b1;
      end else if (m_words == CAP_WORDS) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
      end
      if (i_rx_valid) begin
        if (m_loading)    absorb(i_rx_data);
        else if (m_check) finish_check(i_rx_data);
      end
    end else if (m_loading) begin
      if (i_rx_valid) absorb(i_rx_data);
    end else if (m_check) begin
      if (i_rx_valid) finish_check(i_rx_data);
    end else if (i_start) begin
      model_clear();
      m_loading = 1'b1;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else     model_step();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare thread and write log
  // ---------------------------------------------------------------------------
  logic [31:0] wr_data[$];
  logic [31:0] wr_addr[$];

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("write_enable", o_write_enable, m_wr);
      check("busy", o_busy, m_loading || m_wr || m_check);
      check("done", o_done, m_done);
      check("word_count", o_word_count, m_words);
      check("error", o_error, m_err);
      if (rst) begin
        check("reset_data", o_data, 0);
        check("reset_addr", o_addr_w, 0);
      end else if (m_wr) begin
        check("write_data", o_data, m_wr_word);
        check("write_addr", o_addr_w, m_words * 4);
      end else if (m_done) begin
        check("held_addr", o_addr_w, (m_words - 1) * 4);
      end
      if (o_write_enable && !rst) begin
        wr_data.push_back(o_data);
        wr_addr.push_back(32'(o_addr_w));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
  endtask

  // One-cycle strobe with no trailing gap.
  task automatic send_fast(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  // Strobe followed by the two idle cycles the UART always leaves.
  task automatic send_byte(input logic [7:0] b);
    send_fast(b);
    tick();
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int base;

  initial begin
    fork
      model_loop();
      compare_loop();
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_we", o_write_enable, 0);
    check("rst_data", o_data, 0);
    check("rst_addr", o_addr_w, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_wcnt", o_word_count, 0);
    check("rst_err", o_error, 0);
    rst = 1'b0;
    tick();

    // One word: 01 02 03 04
    base = wr_data.size();
    pulse_start();
    send_word(32'h0102_0304);
    check("t1_nwr", wr_data.size() - base, 1);
    check("t1_data", wr_data[base], 32'h0102_0304);
    check("t1_addr", wr_addr[base], 32'h0);
    check("t1_wcnt", o_word_count, 1);
    check("t1_busy", o_busy, 1);
    check("t1_done", o_done, 0);

    // Program ending on HALT
    do_reset();
    base = wr_data.size();
    pulse_start();
    send_word(32'h1122_3344);
    send_word(HALT);
    repeat (6) tick();
    check("t2_nwr", wr_data.size() - base, 2);
    check("t2_data0", wr_data[base], 32'h1122_3344);
    check("t2_addr0", wr_addr[base], 32'h0);
    check("t2_data1", wr_data[base+1], 32'hFFFF_FFFF);
    check("t2_addr1", wr_addr[base+1], 32'h4);
    check("t2_done", o_done, 1);
    check("t2_busy", o_busy, 0);
    check("t2_wcnt", o_word_count, 2);
    check("t2_addr_held", o_addr_w, 4);

    // Memory full: restart from DONE, 16 non-HALT bytes, then a 17th
    base = wr_data.size();
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
    send_byte(8'h99);
    repeat (4) tick();
    check("t3_nwr", wr_data.size() - base, 4);
    check("t3_addr0", wr_addr[base], 32'h0);
    check("t3_addr1", wr_addr[base+1], 32'h4);
    check("t3_addr2", wr_addr[base+2], 32'h8);
    check("t3_addr3", wr_addr[base+3], 32'hC);
    check("t3_data3", wr_data[base+3], 32'h4C4D_4E4F);
    check("t3_done", o_done, 1);
    check("t3_wcnt", o_word_count, 4);
    check("t3_addr_held", o_addr_w, 4'hC);

    // Reset in the middle of a word
    base = wr_data.size();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst = 1'b1;
    #1;
    check("t4_we", o_write_enable, 0);
    check("t4_busy", o_busy, 0);
    check("t4_data", o_data, 0);
    check("t4_addr", o_addr_w, 0);
    check("t4_wcnt", o_word_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("t4_nwr", wr_data.size() - base, 0);
    base = wr_data.size();
    pulse_start();
    send_word(32'h0506_0708);
    check("t4_data_new", wr_data[base], 32'h0506_0708);
    check("t4_addr_new", wr_addr[base], 32'h0);

    // Byte in the write cycle and start pulses mid-load
    base = wr_data.size();
    i_start = 1'b1;
    send_byte(8'h21);
    i_start = 1'b0;
    send_byte(8'h22);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    send_byte(8'h23);
    send_fast(8'h24);
    send_byte(8'h25);        // strobed during the write of 21222324
    i_start = 1'b1;
    send_byte(8'h26);
    i_start = 1'b0;
    send_byte(8'h27);
    send_byte(8'h28);
    check("t5_nwr", wr_data.size() - base, 2);
    check("t5_data0", wr_data[base], 32'h2122_2324);
    check("t5_addr0", wr_addr[base], 32'h4);
    check("t5_data1", wr_data[base+1], 32'h2526_2728);
    check("t5_addr1", wr_addr[base+1], 32'h8);
    check("t5_wcnt", o_word_count, 3);
    check("t5_busy", o_busy, 1);
    send_word(HALT);
    repeat (3) tick();
    check("t5_done", o_done, 1);
    check("t5_wcnt_end", o_word_count, 4);

`ifdef LOADER_CHECKSUM_EN
    // Checksum byte after HALT: FF^FF^FF^FF = 00
    do_reset();
    pulse_start();
    send_word(HALT);
    check("t6_wait_busy", o_busy, 1);
    check("t6_wait_done", o_done, 0);
    send_byte(8'h00);
    check("t6_done_ok", o_done, 1);
    check("t6_err_ok", o_error, 0);
    pulse_start();
    send_word(HALT);
    send_byte(8'h01);
    check("t6_done_bad", o_done, 1);
    check("t6_err_bad", o_error, 1);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
